// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, select encodings, FSM states
// and the control bundle with its IDLE value.
package cu_pkg;

    localparam logic [1:0] FunDec   = 2'b00;
    localparam logic [1:0] FunInc   = 2'b01;
    localparam logic [1:0] FunLoad  = 2'b10;
    localparam logic [1:0] FunClear = 2'b11;

    localparam logic [1:0] ArfPc = 2'b00;
    localparam logic [1:0] ArfAr = 2'b01;
    localparam logic [1:0] ArfSp = 2'b10;

    localparam logic [3:0] ArfRSelPc = 4'b0001;
    localparam logic [3:0] ArfRSelAr = 4'b0010;
    localparam logic [3:0] ArfRSelSp = 4'b0100;

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpLdi   = 4'h1;
    localparam logic [3:0] OpLd    = 4'h2;
    localparam logic [3:0] OpSt    = 4'h3;
    localparam logic [3:0] OpAlu   = 4'h4;
    localparam logic [3:0] OpLdar  = 4'h5;
    localparam logic [3:0] OpIncar = 4'h6;
    localparam logic [3:0] OpBra   = 4'h7;
    localparam logic [3:0] OpBeq   = 4'h8;
    localparam logic [3:0] OpPush  = 4'h9;
    localparam logic [3:0] OpPop   = 4'hA;
    localparam logic [3:0] OpHlt   = 4'hB;

    typedef enum logic [2:0] {
        StInit,
        StFetchL,
        StFetchH,
        StExec1,
        StExec2,
        StHalt
    } state_t;

    typedef struct packed {
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_r_sel;
        logic [3:0] rf_t_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_a_sel;
        logic [1:0] arf_out_b_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_r_sel;
        logic [1:0] ir_funsel;
        logic       ir_enable;
        logic       ir_lh;
        logic       mem_wr;
        logic       mem_cs;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    // Memory chip select is active-low, so the quiet bundle keeps it high.
    localparam ctrl_t CtrlIdle = '{mem_cs: 1'b1, default: '0};

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of FSM state, instruction and zero flag into the full
// datapath control bundle.
module cu_decoder
    import cu_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        zflag,
    output ctrl_t       ctrl
);

    logic [3:0] op;
    logic [1:0] d;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [3:0] fn;

    assign op = ir[15:12];
    assign d  = ir[11:10];
    assign s1 = ir[9:8];
    assign s2 = ir[7:6];
    assign fn = ir[3:0];

    always_comb begin
        ctrl = CtrlIdle;
        unique case (state)
            StInit: begin
                ctrl.arf_fun_sel = FunClear;
                ctrl.arf_r_sel   = 4'b0111;
                ctrl.rf_fun_sel  = FunClear;
                ctrl.rf_r_sel    = 4'b1111;
                ctrl.rf_t_sel    = 4'b1111;
            end
            StFetchL, StFetchH: begin
                ctrl.arf_out_b_sel = ArfPc;
                ctrl.mem_cs        = 1'b0;
                ctrl.ir_enable     = 1'b1;
                ctrl.ir_funsel     = FunLoad;
                ctrl.ir_lh         = (state == StFetchH);
                ctrl.arf_fun_sel   = FunInc;
                ctrl.arf_r_sel     = ArfRSelPc;
            end
            StExec1: begin
                case (op)
                    OpLdi: begin
                        ctrl.mux_a_sel  = 2'b10;
                        ctrl.rf_fun_sel = FunLoad;
                        ctrl.rf_r_sel   = reg_onehot(d);
                    end
                    OpLd, OpPop: begin
                        ctrl.arf_out_b_sel = (op == OpLd) ? ArfAr : ArfSp;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mux_a_sel     = 2'b01;
                        ctrl.rf_fun_sel    = FunLoad;
                        ctrl.rf_r_sel      = reg_onehot(d);
                    end
                    OpSt: begin
                        ctrl.rf_out_b_sel  = {1'b0, d};
                        ctrl.alu_fun_sel   = 4'b0001;
                        ctrl.arf_out_b_sel = ArfAr;
                        ctrl.mem_cs        = 1'b0;
                        ctrl.mem_wr        = 1'b1;
                    end
                    OpAlu: begin
                        ctrl.rf_out_a_sel = {1'b0, s1};
                        ctrl.rf_out_b_sel = {1'b0, s2};
                        ctrl.alu_fun_sel  = fn;
                        ctrl.rf_fun_sel   = FunLoad;
                        ctrl.rf_r_sel     = reg_onehot(d);
                    end
                    OpLdar: begin
                        ctrl.mux_b_sel   = 2'b10;
                        ctrl.arf_fun_sel = FunLoad;
                        ctrl.arf_r_sel   = ArfRSelAr;
                    end
                    OpIncar: begin
                        ctrl.arf_fun_sel = FunInc;
                        ctrl.arf_r_sel   = ArfRSelAr;
                    end
                    OpBra, OpBeq: begin
                        if (op == OpBra || zflag) begin
                            ctrl.mux_b_sel   = 2'b10;
                            ctrl.arf_fun_sel = FunLoad;
                            ctrl.arf_r_sel   = ArfRSelPc;
                        end
                    end
                    OpPush: begin
                        ctrl.arf_fun_sel = FunDec;
                        ctrl.arf_r_sel   = ArfRSelSp;
                    end
                    OpNop, OpHlt: ;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            StExec2: begin
                if (op == OpPush) begin
                    ctrl.rf_out_b_sel  = {1'b0, d};
                    ctrl.alu_fun_sel   = 4'b0001;
                    ctrl.arf_out_b_sel = ArfSp;
                    ctrl.mem_cs        = 1'b0;
                    ctrl.mem_wr        = 1'b1;
                end else begin
                    ctrl.arf_fun_sel = FunInc;
                    ctrl.arf_r_sel   = ArfRSelSp;
                end
            end
            StHalt: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer for ALU_System: two-byte fetch, decode and
// 1-2 cycle execute, with a zero flag captured from ALU instructions.
module control_unit
    import cu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_ZCNO,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic [1:0]  IR_Funsel,
    output logic        IR_Enable,
    output logic        IR_LH,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic        Halted,
    output logic        Illegal
);

    state_t     state_q, state_d;
    logic       zflag_q, zflag_d;
    logic [3:0] op;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;

    assign op = IR_Out[15:12];

    cu_decoder u_decoder (
        .state (state_q),
        .ir    (IR_Out),
        .zflag (zflag_q),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        state_d = state_q;
        zflag_d = zflag_q;
        unique case (state_q)
            StInit:   state_d = StFetchL;
            StFetchL: state_d = StFetchH;
            StFetchH: state_d = StExec1;
            StExec1: begin
                state_d = StFetchL;
                if (op == OpAlu) zflag_d = ALU_ZCNO[3];
                if (op == OpPush || op == OpPop) state_d = StExec2;
                else if (op == OpHlt) state_d = StHalt;
                else if (op > OpHlt && HALT_ON_ILLEGAL) state_d = StHalt;
            end
            StExec2:  state_d = StFetchL;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= StInit;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zflag_q <= zflag_d;
        end
    end

    // Reset held low masks everything, so nothing is written while it is asserted.
    assign ctrl = Reset ? dec_ctrl : CtrlIdle;

    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RSel     = ctrl.rf_r_sel;
    assign RF_TSel     = ctrl.rf_t_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_OutASel = ctrl.arf_out_a_sel;
    assign ARF_OutBSel = ctrl.arf_out_b_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RSel    = ctrl.arf_r_sel;
    assign IR_Funsel   = ctrl.ir_funsel;
    assign IR_Enable   = ctrl.ir_enable;
    assign IR_LH       = ctrl.ir_lh;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign Halted      = ctrl.halted;
    assign Illegal     = ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks reset, fetch and a set of instructions
// through the sequencer and checks the control strobes at each state.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_ZCNO;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic [1:0]  IR_Funsel;
    logic        IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 Clock = ~Clock;

    control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IR_Out      (IR_Out),
        .ALU_ZCNO    (ALU_ZCNO),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RSel     (RF_RSel),
        .RF_TSel     (RF_TSel),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_OutASel (ARF_OutASel),
        .ARF_OutBSel (ARF_OutBSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RSel    (ARF_RSel),
        .IR_Funsel   (IR_Funsel),
        .IR_Enable   (IR_Enable),
        .IR_LH       (IR_LH),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .Halted      (Halted),
        .Illegal     (Illegal)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // From FETCH_L: step through FETCH_H into EXEC1 with the given instruction.
    task automatic to_exec1(input logic [15:0] instr);
        tick();
        chk("fetch_h_lh", {15'd0, IR_LH}, 16'd1);
        IR_Out = instr;
        tick();
        #1;
    endtask

    initial begin
        Reset    = 1'b0;
        IR_Out   = 16'h0000;
        ALU_ZCNO = 4'b0000;
        tick();
        tick();
        chk("rst_cs", {15'd0, Mem_CS}, 16'd1);
        chk("rst_arf_rsel", {12'd0, ARF_RSel}, 16'd0);
        chk("rst_rf_rsel", {12'd0, RF_RSel}, 16'd0);
        chk("rst_ir_en", {15'd0, IR_Enable}, 16'd0);
        chk("rst_halted", {15'd0, Halted}, 16'd0);

        Reset = 1'b1;
        #1;
        chk("init_arf_rsel", {12'd0, ARF_RSel}, 16'h0007);
        chk("init_arf_fun", {14'd0, ARF_FunSel}, 16'h0003);
        chk("init_rf_rsel", {12'd0, RF_RSel}, 16'h000F);
        chk("init_rf_tsel", {12'd0, RF_TSel}, 16'h000F);

        tick();
        chk("fetch_l_lh", {15'd0, IR_LH}, 16'd0);
        chk("fetch_l_en", {15'd0, IR_Enable}, 16'd1);
        chk("fetch_l_cs", {15'd0, Mem_CS}, 16'd0);
        chk("fetch_l_arf", {12'd0, ARF_RSel}, 16'h0001);
        chk("fetch_l_arffun", {14'd0, ARF_FunSel}, 16'h0001);
        chk("fetch_l_irfun", {14'd0, IR_Funsel}, 16'h0002);

        // LDI R2,#5A
        to_exec1(16'h185A);
        chk("ldi_muxa", {14'd0, MuxASel}, 16'h0002);
        chk("ldi_rsel", {12'd0, RF_RSel}, 16'h0004);
        chk("ldi_fun", {14'd0, RF_FunSel}, 16'h0002);
        tick();
        chk("ldi_next_fetch", {15'd0, IR_Enable}, 16'd1);

        // ADD R0 = R1 + R2 producing Z=1
        ALU_ZCNO = 4'b1000;
        to_exec1(16'h4184);
        chk("add_outa", {13'd0, RF_OutASel}, 16'h0001);
        chk("add_outb", {13'd0, RF_OutBSel}, 16'h0002);
        chk("add_alufun", {12'd0, ALU_FunSel}, 16'h0004);
        chk("add_rsel", {12'd0, RF_RSel}, 16'h0001);
        chk("add_muxa", {14'd0, MuxASel}, 16'h0000);
        tick();
        ALU_ZCNO = 4'b0000;

        // BEQ taken
        to_exec1(16'h8040);
        chk("beq_t_muxb", {14'd0, MuxBSel}, 16'h0002);
        chk("beq_t_arf", {12'd0, ARF_RSel}, 16'h0001);
        chk("beq_t_fun", {14'd0, ARF_FunSel}, 16'h0002);
        tick();

        // ADD producing Z=0, then BEQ with Z high on the ALU (must be ignored)
        to_exec1(16'h4184);
        tick();
        ALU_ZCNO = 4'b1000;
        to_exec1(16'h8040);
        chk("beq_nt_arf", {12'd0, ARF_RSel}, 16'h0000);
        chk("beq_nt_muxb", {14'd0, MuxBSel}, 16'h0000);
        tick();
        to_exec1(16'h8040);
        chk("beq_nt2_arf", {12'd0, ARF_RSel}, 16'h0000);
        tick();
        ALU_ZCNO = 4'b0000;

        // ST R2
        to_exec1(16'h3800);
        chk("st_outb", {13'd0, RF_OutBSel}, 16'h0002);
        chk("st_wr", {15'd0, Mem_WR}, 16'd1);
        chk("st_arfb", {14'd0, ARF_OutBSel}, 16'h0001);
        tick();

        // PUSH R3
        to_exec1(16'h9C00);
        chk("push1_fun", {14'd0, ARF_FunSel}, 16'h0000);
        chk("push1_arf", {12'd0, ARF_RSel}, 16'h0004);
        chk("push1_wr", {15'd0, Mem_WR}, 16'd0);
        tick();
        chk("push2_wr", {15'd0, Mem_WR}, 16'd1);
        chk("push2_cs", {15'd0, Mem_CS}, 16'd0);
        chk("push2_arfb", {14'd0, ARF_OutBSel}, 16'h0002);
        chk("push2_outb", {13'd0, RF_OutBSel}, 16'h0003);
        chk("push2_alufun", {12'd0, ALU_FunSel}, 16'h0001);
        tick();
        chk("push_next_fetch", {15'd0, IR_Enable}, 16'd1);

        // POP R1
        to_exec1(16'hA400);
        chk("pop1_rsel", {12'd0, RF_RSel}, 16'h0002);
        chk("pop1_muxa", {14'd0, MuxASel}, 16'h0001);
        chk("pop1_arfb", {14'd0, ARF_OutBSel}, 16'h0002);
        chk("pop1_cs", {15'd0, Mem_CS}, 16'd0);
        tick();
        chk("pop2_fun", {14'd0, ARF_FunSel}, 16'h0001);
        chk("pop2_arf", {12'd0, ARF_RSel}, 16'h0004);
        chk("pop2_cs", {15'd0, Mem_CS}, 16'd1);
        tick();

        // Reset asserted during PUSH EXEC2 aborts it
        to_exec1(16'h9C00);
        tick();
        Reset = 1'b0;
        #1;
        chk("abort_wr", {15'd0, Mem_WR}, 16'd0);
        chk("abort_cs", {15'd0, Mem_CS}, 16'd1);
        tick();
        Reset = 1'b1;
        #1;
        chk("abort_init", {12'd0, ARF_RSel}, 16'h0007);
        tick();
        chk("abort_fetch", {15'd0, IR_LH}, 16'd0);

        // Illegal opcode halts
        to_exec1(16'hF000);
        chk("ill_pulse", {15'd0, Illegal}, 16'd1);
        chk("ill_halted", {15'd0, Halted}, 16'd0);
        tick();
        chk("halt_1", {15'd0, Halted}, 16'd1);
        chk("halt_ill", {15'd0, Illegal}, 16'd0);
        chk("halt_cs", {15'd0, Mem_CS}, 16'd1);
        tick();
        tick();
        chk("halt_stays", {15'd0, Halted}, 16'd1);
        Reset = 1'b0;
        #1;
        chk("halt_rst", {15'd0, Halted}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
